alu_req_arbiter: RTL

- Shares one ALU instance among N_REQ requesters; one operation in flight at a time.
- Arbitrates round-robin, latches the winner's operands, and drives the ALU with a one-cycle CE pulse.
- Waits a command-dependent latency, captures RES and flags, and returns them tagged with the requester ID over a valid/ready response port.
- Sits between the testbench-facing request agents and the ALU DUT.

---
 rtl/alu_arb_pkg.sv | 40 ++++
 rtl/alu_req_arbiter_rr_grant.sv | 34 +++
 rtl/alu_req_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU request arbiter: FSM states,
// multiply command codes, latency selection and the captured response record.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [15:0] MUL_CMD_A = 16'd9;
  localparam logic [15:0] MUL_CMD_B = 16'd10;

  // Widest result the response record can hold (supports N up to 32).
  localparam int RES_MAX_W = 33;

  typedef struct packed {
    logic [RES_MAX_W-1:0] res;
    logic                 err;
    logic                 oflow;
    logic                 cout;
    logic                 g;
    logic                 l;
    logic                 e;
  } alu_rsp_t;

  // High when the command runs on the multiplier and needs the longer latency.
  function automatic logic lat_sel(input logic mode, input logic [15:0] cmd);
    logic sel;
    sel = 1'b0;
    if (mode && ((cmd == MUL_CMD_A) || (cmd == MUL_CMD_B))) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    return sel;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_grant.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around, returned both one-hot and as an index.
module rr_grant #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    logic [IDX_W-1:0] pos_s;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos_s = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[pos_s]) begin
        found      = 1'b1;
        gnt[pos_s] = 1'b1;
        idx        = pos_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among N_REQ requesters: round-robin grant, one-cycle CE issue,
// latency-timed result capture and an ID-tagged valid/ready response.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         REQ_VALID,
  output logic [N_REQ-1:0]         REQ_READY,
  input  logic [N_REQ*N-1:0]       REQ_OPA,
  input  logic [N_REQ*N-1:0]       REQ_OPB,
  input  logic [N_REQ*M-1:0]       REQ_CMD,
  input  logic [N_REQ-1:0]         REQ_MODE,
  input  logic [N_REQ-1:0]         REQ_CIN,
  input  logic [N_REQ*2-1:0]       REQ_INP_VALID,
  output logic [N-1:0]             ALU_OPA,
  output logic [N-1:0]             ALU_OPB,
  output logic [M-1:0]             ALU_CMD,
  output logic                     ALU_MODE,
  output logic                     ALU_CIN,
  output logic                     ALU_CE,
  output logic [1:0]               ALU_INP_VALID,
  input  logic [N:0]               ALU_RES,
  input  logic                     ALU_ERR,
  input  logic                     ALU_OFLOW,
  input  logic                     ALU_COUT,
  input  logic                     ALU_G,
  input  logic                     ALU_L,
  input  logic                     ALU_E,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [$clog2(N_REQ)-1:0] RSP_ID,
  output logic [N:0]               RSP_RES,
  output logic                     RSP_ERR,
  output logic                     RSP_OFLOW,
  output logic                     RSP_COUT,
  output logic                     RSP_G,
  output logic                     RSP_L,
  output logic                     RSP_E,
  output logic                     BUSY
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 8;

  arb_state_t       state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [N-1:0]     alu_opa_r;
  logic [N-1:0]     alu_opb_r;
  logic [M-1:0]     alu_cmd_r;
  logic             alu_mode_r;
  logic             alu_cin_r;
  logic             alu_ce_r;
  logic [1:0]       alu_iv_r;
  alu_rsp_t         rsp_r;
  logic             rsp_valid_r;
  logic             busy_r;

  logic [N_REQ-1:0] win_gnt_s;
  logic [IDX_W-1:0] win_idx_s;
  logic             win_found_s;
  logic [N_REQ-1:0] ready_s;
  logic [N-1:0]     sel_opa_s;
  logic [N-1:0]     sel_opb_s;
  logic [M-1:0]     sel_cmd_s;
  logic             sel_mode_s;
  logic             sel_cin_s;
  logic [1:0]       sel_iv_s;
  logic [IDX_W-1:0] ptr_next_s;
  logic [CNT_W-1:0] lat_load_s;

  rr_grant #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req  (REQ_VALID),
    .ptr  (ptr_r),
    .gnt  (win_gnt_s),
    .idx  (win_idx_s),
    .found(win_found_s)
  );

  // Grant is only offered while idle and out of reset, so READY is 0 during reset.
  always_comb begin
    ready_s = '0;
    if ((state_r == IDLE) && RST) begin
      ready_s = win_gnt_s;
    end else begin
      ready_s = '0;
    end
  end

  // One-hot grant selects the winner's payload with an AND-OR mux.
  always_comb begin
    sel_opa_s  = '0;
    sel_opb_s  = '0;
    sel_cmd_s  = '0;
    sel_mode_s = 1'b0;
    sel_cin_s  = 1'b0;
    sel_iv_s   = 2'b00;
    for (int i = 0; i < N_REQ; i++) begin
      sel_opa_s  = sel_opa_s  | (REQ_OPA[i*N +: N] & {N{win_gnt_s[i]}});
      sel_opb_s  = sel_opb_s  | (REQ_OPB[i*N +: N] & {N{win_gnt_s[i]}});
      sel_cmd_s  = sel_cmd_s  | (REQ_CMD[i*M +: M] & {M{win_gnt_s[i]}});
      sel_mode_s = sel_mode_s | (REQ_MODE[i] & win_gnt_s[i]);
      sel_cin_s  = sel_cin_s  | (REQ_CIN[i] & win_gnt_s[i]);
      sel_iv_s   = sel_iv_s   | (REQ_INP_VALID[i*2 +: 2] & {2{win_gnt_s[i]}});
    end
  end

  // Pointer advance past the served requester and latency selection for the counter.
  always_comb begin
    ptr_next_s = '0;
    lat_load_s = '0;
    if (gnt_idx_r == IDX_W'(N_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_idx_r + IDX_W'(1);
    end
    if (lat_sel(alu_mode_r, 16'(alu_cmd_r))) begin
      lat_load_s = CNT_W'(MUL_LAT - 1);
    end else begin
      lat_load_s = CNT_W'(ALU_LAT - 1);
    end
  end

  // Main FSM; ALU and response registers only load on their own transitions.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      gnt_idx_r   <= '0;
      cnt_r       <= '0;
      alu_opa_r   <= '0;
      alu_opb_r   <= '0;
      alu_cmd_r   <= '0;
      alu_mode_r  <= 1'b0;
      alu_cin_r   <= 1'b0;
      alu_ce_r    <= 1'b0;
      alu_iv_r    <= 2'b00;
      rsp_r       <= '0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            alu_opa_r  <= sel_opa_s;
            alu_opb_r  <= sel_opb_s;
            alu_cmd_r  <= sel_cmd_s;
            alu_mode_r <= sel_mode_s;
            alu_cin_r  <= sel_cin_s;
            alu_iv_r   <= sel_iv_s;
            gnt_idx_r  <= win_idx_s;
            alu_ce_r   <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          alu_ce_r <= 1'b0;
          cnt_r    <= lat_load_s;
          state_r  <= WAIT;
        end
        WAIT: begin
          if (cnt_r == CNT_W'(0)) begin
            rsp_r.res   <= RES_MAX_W'(ALU_RES);
            rsp_r.err   <= ALU_ERR;
            rsp_r.oflow <= ALU_OFLOW;
            rsp_r.cout  <= ALU_COUT;
            rsp_r.g     <= ALU_G;
            rsp_r.l     <= ALU_L;
            rsp_r.e     <= ALU_E;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          if (RSP_READY) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ptr_r       <= ptr_next_s;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          alu_ce_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Zero padding of the shared response record above the result width.
  generate
    if (N + 1 < RES_MAX_W) begin : g_res_pad
      logic unused_pad_s;
      assign unused_pad_s = ^rsp_r.res[RES_MAX_W-1:N+1];
    end
  endgenerate

  assign REQ_READY     = ready_s;
  assign ALU_OPA       = alu_opa_r;
  assign ALU_OPB       = alu_opb_r;
  assign ALU_CMD       = alu_cmd_r;
  assign ALU_MODE      = alu_mode_r;
  assign ALU_CIN       = alu_cin_r;
  assign ALU_CE        = alu_ce_r;
  assign ALU_INP_VALID = alu_iv_r;
  assign RSP_VALID     = rsp_valid_r;
  assign RSP_ID        = gnt_idx_r;
  assign RSP_RES       = rsp_r.res[N:0];
  assign RSP_ERR       = rsp_r.err;
  assign RSP_OFLOW     = rsp_r.oflow;
  assign RSP_COUT      = rsp_r.cout;
  assign RSP_G         = rsp_r.g;
  assign RSP_L         = rsp_r.l;
  assign RSP_E         = rsp_r.e;
  assign BUSY          = busy_r;

endmodule
